// File: rtl/noc_packet_arbiter.sv
// Packet-granular round-robin arbiter for one valid/ready NoC channel.
// Grant locks from header to tail; forwarding path is combinational.
module noc_packet_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int FLIT_W  = 64,
  parameter int LEN_MSB = 29,
  parameter int LEN_LSB = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*FLIT_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      dst_valid,
  output logic [FLIT_W-1:0]         dst_data,
  input  logic                      dst_ready,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LW = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] lock_id_q, lock_id_d;
  logic [LW-1:0] remain_q, remain_d;

  logic [PW-1:0]      sel;
  logic [PW-1:0]      cand;
  logic               found;
  logic               xfer;
  logic [LW-1:0]      hdr_len;
  logic [NUM_SRC-1:0] grant_int;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_SRC - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scan starting at rr_ptr for the first valid source
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && src_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Grant: live arbitration when idle, locked source when busy
  always_comb begin
    grant_int = '0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: if (found) grant_int[sel] = 1'b1;
        BUSY: grant_int[lock_id_q] = 1'b1;
        default: grant_int = '0;
      endcase
    end
  end

  // Forwarding mux and handshake; dst_valid never depends on dst_ready
  always_comb begin
    dst_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_int[i]) dst_data = dst_data | src_data[i*FLIT_W +: FLIT_W];
    end
  end

  assign grant     = grant_int;
  assign dst_valid = |(grant_int & src_valid);
  assign src_ready = grant_int & {NUM_SRC{dst_ready}};
  assign xfer      = dst_valid & dst_ready;
  assign hdr_len   = dst_data[LEN_MSB:LEN_LSB];
  assign busy      = (state_q == BUSY);

  // Next-state: lock on multi-flit header, release and advance on tail
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    remain_d  = remain_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            rr_ptr_d = ptr_inc(sel);
          end else begin
            state_d   = BUSY;
            lock_id_d = sel;
            remain_d  = hdr_len;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == LW'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(lock_id_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      remain_q  <= remain_d;
    end
  end

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Directed testbench for noc_packet_arbiter.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_noc_packet_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   src_valid;
  logic [255:0] src_data;
  logic [3:0]   src_ready;
  logic         dst_valid;
  logic [63:0]  dst_data;
  logic         dst_ready;
  logic [3:0]   grant;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  noc_packet_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_ready (dst_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input int id, input int len, input int tag);
    logic [63:0] h;
    h = '0;
    h[63:60] = id[3:0];
    h[29:22] = len[7:0];
    h[15:0]  = tag[15:0];
    return h;
  endfunction

  function automatic logic [63:0] pl(input int id, input int n);
    logic [63:0] h;
    h = '0;
    h[63:60] = id[3:0];
    h[47:32] = 16'hBEEF;
    h[15:0]  = n[15:0];
    return h;
  endfunction

  task automatic set_src(input int i, input logic [63:0] d);
    src_data[i*64 +: 64] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_valid = 4'hF;
    src_data = {4{hdr(0, 3, 1)}};
    dst_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({src_ready, dst_valid, grant, busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outs got rdy=%b dv=%b g=%b busy=%b exp all 0",
               src_ready, dst_valid, grant, busy);
    end
    n_checks++;
    if (dst_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0", dst_data);
    end
    tick();
    rst_n = 1'b1;
    src_valid = 4'h0;
    src_data = '0;
    tick();
  endtask

  task automatic test_single();
    int nx;
    nx = 0;
    dst_ready = 1'b1;
    src_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      set_src(1, (c == 0) ? hdr(1, 2, 1) : pl(1, c));
      @(negedge clk);
      if (dst_valid && dst_ready) nx++;
      n_checks++;
      if ({grant, src_ready, dst_valid, busy} !== {4'b0010, 4'b0010, 1'b1, (c != 0)}) begin
        n_fail++;
        $display("FAIL single_c%0d got g=%b rdy=%b dv=%b busy=%b exp g=0010 rdy=0010 dv=1 busy=%b",
                 c, grant, src_ready, dst_valid, busy, (c != 0));
      end
      n_checks++;
      if (dst_data !== ((c == 0) ? hdr(1, 2, 1) : pl(1, c))) begin
        n_fail++;
        $display("FAIL single_data_c%0d got %h", c, dst_data);
      end
      tick();
    end
    n_checks++;
    if (nx !== 3) begin
      n_fail++;
      $display("FAIL single_xfers got %0d exp 3", nx);
    end
    // rr_ptr must now be 2: src2 wins over src0 and src3
    src_valid = 4'b1101;
    set_src(0, hdr(0, 0, 10));
    set_src(2, hdr(2, 0, 12));
    set_src(3, hdr(3, 0, 13));
    dst_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant, src_ready, dst_valid, busy} !== {4'b0100, 4'b0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_rrptr got g=%b rdy=%b dv=%b busy=%b exp g=0100 rdy=0000 dv=1 busy=0",
               grant, src_ready, dst_valid, busy);
    end
    n_checks++;
    if (dst_data !== hdr(2, 0, 12)) begin
      n_fail++;
      $display("FAIL single_rrptr_data got %h exp %h", dst_data, hdr(2, 0, 12));
    end
    tick();
    src_valid = 4'b0;
    dst_ready = 1'b1;
  endtask

  task automatic test_lock();
    // rr_ptr is 2; only src0 valid at first
    src_valid = 4'b0001;
    set_src(0, hdr(0, 3, 20));
    @(negedge clk);
    n_checks++;
    if ({grant, dst_valid, busy} !== {4'b0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_hdr got g=%b dv=%b busy=%b exp g=0001 dv=1 busy=0",
               grant, dst_valid, busy);
    end
    tick();
    src_valid = 4'b0101;
    set_src(2, hdr(2, 0, 22));
    for (int c = 1; c <= 3; c++) begin
      set_src(0, pl(0, c));
      @(negedge clk);
      n_checks++;
      if ({grant, dst_valid, busy, dst_data} !== {4'b0001, 1'b1, 1'b1, pl(0, c)}) begin
        n_fail++;
        $display("FAIL lock_flit%0d got g=%b dv=%b busy=%b d=%h exp g=0001 dv=1 busy=1 d=%h",
                 c, grant, dst_valid, busy, dst_data, pl(0, c));
      end
      tick();
    end
    src_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({grant, dst_valid, busy, dst_data} !== {4'b0100, 1'b1, 1'b0, hdr(2, 0, 22)}) begin
      n_fail++;
      $display("FAIL lock_next got g=%b dv=%b busy=%b d=%h exp g=0100 dv=1 busy=0 d=%h",
               grant, dst_valid, busy, dst_data, hdr(2, 0, 22));
    end
    tick();
    src_valid = 4'b0;
    @(negedge clk);
    n_checks++;
    if ({grant, dst_valid, dst_data} !== {4'b0000, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL lock_idle got g=%b dv=%b d=%h exp g=0000 dv=0 d=0",
               grant, dst_valid, dst_data);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int sent [4];
    logic [3:0] pop;
    logic [3:0] exp_g;
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) sent[i] = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    dst_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) begin
        src_valid[i] = (sent[i] < 5);
        set_src(i, hdr(i, 0, sent[i]));
      end
      @(negedge clk);
      exp_g = 4'b0001 << (c % 4);
      pop = src_valid & src_ready;
      n_checks++;
      if ({grant, dst_valid, dst_data} !== {exp_g, 1'b1, hdr(c % 4, 0, c / 4)}) begin
        n_fail++;
        errs++;
        if (errs < 5)
          $display("FAIL rr_hdr%0d got g=%b dv=%b d=%h exp g=%b dv=1 d=%h",
                   c, grant, dst_valid, dst_data, exp_g, hdr(c % 4, 0, c / 4));
      end
      tick();
      for (int i = 0; i < 4; i++) if (pop[i]) sent[i]++;
    end
    for (int i = 0; i < 4; i++) src_valid[i] = (sent[i] < 5);
    @(negedge clk);
    n_checks++;
    if ({sent[0], sent[1], sent[2], sent[3]} !== {32'd5, 32'd5, 32'd5, 32'd5}) begin
      n_fail++;
      $display("FAIL rr_counts got %0d %0d %0d %0d exp 5 5 5 5",
               sent[0], sent[1], sent[2], sent[3]);
    end
    n_checks++;
    if ({grant, dst_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL rr_done got g=%b dv=%b exp 0", grant, dst_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] v_pat [4];
    logic       r_pat [4];
    logic [3:0] exp_rdy;
    int nx;
    v_pat = '{4'b1000, 4'b1000, 4'b0000, 4'b1000};
    r_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    nx = 0;
    for (int c = 0; c < 4; c++) begin
      src_valid = v_pat[c];
      dst_ready = r_pat[c];
      set_src(3, (c == 0) ? hdr(3, 1, 30) : pl(3, 7));
      @(negedge clk);
      if (dst_valid && dst_ready) nx++;
      exp_rdy = r_pat[c] ? 4'b1000 : 4'b0000;
      n_checks++;
      if ({grant, src_ready, dst_valid, busy} !== {4'b1000, exp_rdy, v_pat[c][3], (c != 0)}) begin
        n_fail++;
        $display("FAIL bp_c%0d got g=%b rdy=%b dv=%b busy=%b exp g=1000 rdy=%b dv=%b busy=%b",
                 c, grant, src_ready, dst_valid, busy, exp_rdy, v_pat[c][3], (c != 0));
      end
      if (c > 0) begin
        n_checks++;
        if (dst_data !== pl(3, 7)) begin
          n_fail++;
          $display("FAIL bp_data_c%0d got %h exp %h", c, dst_data, pl(3, 7));
        end
      end
      tick();
    end
    src_valid = 4'b0;
    dst_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (nx !== 2) begin
      n_fail++;
      $display("FAIL bp_xfers got %0d exp 2", nx);
    end
    n_checks++;
    if ({grant, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL bp_end got g=%b busy=%b exp 0", grant, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    dst_ready = 1'b1;
    src_valid = 4'b0001;
    set_src(0, hdr(0, 4, 40));
    tick();
    set_src(0, pl(0, 1));
    tick();
    src_valid = 4'b0011;
    set_src(0, pl(0, 2));
    set_src(1, hdr(1, 0, 41));
    @(negedge clk);
    n_checks++;
    if ({grant, busy} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_pre got g=%b busy=%b exp g=0001 busy=1", grant, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, src_ready, dst_valid, busy, dst_data} !== 74'b0) begin
      n_fail++;
      $display("FAIL rmid_zero got g=%b rdy=%b dv=%b busy=%b d=%h exp all 0",
               grant, src_ready, dst_valid, busy, dst_data);
    end
    tick();
    rst_n = 1'b1;
    set_src(0, hdr(0, 0, 42));
    @(negedge clk);
    n_checks++;
    if ({grant, busy, dst_data} !== {4'b0001, 1'b0, hdr(0, 0, 42)}) begin
      n_fail++;
      $display("FAIL rmid_fresh got g=%b busy=%b d=%h exp g=0001 busy=0 d=%h",
               grant, busy, dst_data, hdr(0, 0, 42));
    end
    tick();
    src_valid = 4'b0110;
    set_src(2, hdr(2, 0, 43));
    @(negedge clk);
    n_checks++;
    if ({grant, dst_data} !== {4'b0010, hdr(1, 0, 41)}) begin
      n_fail++;
      $display("FAIL rmid_next got g=%b d=%h exp g=0010 d=%h",
               grant, dst_data, hdr(1, 0, 41));
    end
    tick();
    src_valid = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
